// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_cpu_if / dcache_mem_if
//  Purpose  : Bus bundles for the L1 data cache.
//             dcache_cpu_if - CPU MEM-stage data port (master = CPU,
//                             slave = cache).
//             dcache_mem_if - block port toward main data memory
//                             (master = cache, slave = memory).
//  Signals  : dcache_cpu_if: READ[3:0], WRITE[2:0], ADDRESS[31:0],
//                            WRITE_DATA[31:0], READ_DATA[31:0], BUSYWAIT
//             dcache_mem_if: MEM_READ, MEM_WRITE, MEM_ADDRESS[27:0],
//                            MEM_WRITE_DATA[127:0], MEM_READ_DATA[127:0],
//                            MEM_BUSYWAIT
//  Revision : 1.0 - initial release
// ============================================================================
interface dcache_cpu_if;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITE_DATA,
                  input  READ_DATA, BUSYWAIT);
  modport slave  (input  READ, WRITE, ADDRESS, WRITE_DATA,
                  output READ_DATA, BUSYWAIT);
endinterface

interface dcache_mem_if;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITE_DATA;
  logic [127:0] MEM_READ_DATA;
  logic         MEM_BUSYWAIT;

  modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA,
                  input  MEM_READ_DATA, MEM_BUSYWAIT);
  modport slave  (input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA,
                  output MEM_READ_DATA, MEM_BUSYWAIT);
endinterface
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache
//  Purpose  : Direct-mapped, write-back, write-allocate L1 data cache with
//             16-byte blocks. Loads hit with zero stall; misses stall the CPU
//             through BUSYWAIT while a dirty victim is written back and the
//             block is refilled.
//  Ports    : CLK, RESET        - clock, asynchronous active-high reset
//             cpu  (slave)      - CPU data port (READ/WRITE/ADDRESS/...)
//             mem  (master)     - block port to main memory
//             HIT_COUNT         - request hit counter (0 unless stats enabled)
//             MISS_COUNT        - miss counter        (0 unless stats enabled)
//  Options  : DCACHE_STATS_EN   - when defined, builds the saturating
//                                 hit/miss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  dcache_cpu_if.slave      cpu,
  dcache_mem_if.master     mem,
  output logic [31:0]      HIT_COUNT,
  output logic [31:0]      MISS_COUNT
);

  localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t                r_state, w_next_state;
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [127:0]          r_data [LINES];
  logic [31:0]           r_read_data;

  logic [3:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_req, w_load, w_store, w_hit;
  logic                  w_load_hit, w_store_hit;
  logic [127:0]          w_line, w_store_line;
  logic [31:0]           w_word, w_load_val;
  logic [15:0]           w_half;
  logic [7:0]            w_byte;
  logic                  w_mem_read, w_mem_write;
  logic [27:0]           w_mem_addr;

  assign w_offset = cpu.ADDRESS[3:0];
  assign w_index  = cpu.ADDRESS[4 +: INDEX_BITS];
  assign w_tag    = cpu.ADDRESS[31 -: TAG_BITS];

  // A store wins over a simultaneous load; the load field is then ignored.
  assign w_store = cpu.WRITE[2];
  assign w_load  = cpu.READ[3] & ~cpu.WRITE[2];
  assign w_req   = cpu.READ[3] | cpu.WRITE[2];

  assign w_line  = r_data[w_index];
  assign w_hit   = r_valid[w_index] & (r_tag[w_index] == w_tag);

  assign w_load_hit  = (r_state == S_IDLE) & w_load  & w_hit;
  assign w_store_hit = (r_state == S_IDLE) & w_store & w_hit;

  // Load lane selection: halfword ignores bit 0, word ignores bits 1:0.
  assign w_word = w_line[{w_offset[3:2], 5'b0} +: 32];
  assign w_half = w_word[{w_offset[1], 4'b0} +: 16];
  assign w_byte = w_word[{w_offset[1:0], 3'b0} +: 8];

  always_comb begin
    w_load_val = w_word;
    case (cpu.READ[2:0])
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'b0, w_byte};
      3'b101:  w_load_val = {16'b0, w_half};
      default: w_load_val = w_word;
    endcase
  end

  always_comb begin
    w_store_line = w_line;
    case (cpu.WRITE[1:0])
      2'b00:   w_store_line[{w_offset, 3'b0} +: 8]         = cpu.WRITE_DATA[7:0];
      2'b01:   w_store_line[{w_offset[3:1], 4'b0} +: 16]   = cpu.WRITE_DATA[15:0];
      default: w_store_line[{w_offset[3:2], 5'b0} +: 32]   = cpu.WRITE_DATA;
    endcase
  end

  // Load hits bypass straight to the output; otherwise the last load holds.
  assign cpu.READ_DATA = w_load_hit ? w_load_val : r_read_data;
  // Reset must drop the stall at once even if the CPU still drives a request.
  assign cpu.BUSYWAIT  = ~RESET & ((r_state != S_IDLE) | (w_req & ~w_hit));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_read_data <= 32'd0;
    end else if (w_load_hit) begin
      r_read_data <= w_load_val;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_addr   = cpu.ADDRESS[31:4];
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        w_mem_write = 1'b1;
        w_mem_addr  = {r_tag[w_index], w_index};
        if (!mem.MEM_BUSYWAIT) w_next_state = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        w_mem_read = 1'b1;
        if (!mem.MEM_BUSYWAIT) w_next_state = S_UPDATE;
      end
      S_UPDATE: begin
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign mem.MEM_READ       = w_mem_read;
  assign mem.MEM_WRITE      = w_mem_write;
  assign mem.MEM_ADDRESS    = w_mem_addr;
  assign mem.MEM_WRITE_DATA = w_line;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_UPDATE) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_store_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (r_state == S_UPDATE) begin
      r_data[w_index] <= mem.MEM_READ_DATA;
      r_tag[w_index]  <= w_tag;
    end else if (w_store_hit) begin
      r_data[w_index] <= w_store_line;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_retry;

  // r_retry marks the held request after a miss so its final hit is not
  // counted a second time.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
      r_retry      <= 1'b0;
    end else if ((r_state == S_IDLE) && w_req) begin
      if (w_hit) begin
        if (!r_retry && (r_hit_count != 32'hFFFF_FFFF)) r_hit_count <= r_hit_count + 32'd1;
        r_retry <= 1'b0;
      end else begin
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
        r_retry <= 1'b1;
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`else
  assign HIT_COUNT  = 32'd0;
  assign MISS_COUNT = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_cache
//  Purpose  : Self-checking bench for data_cache. A byte-level memory image
//             (stores overlaid on a backing block store) predicts every load;
//             a memory responder serves block requests with random latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] HIT_COUNT, MISS_COUNT;

  dcache_cpu_if cpu ();
  dcache_mem_if mem ();

  data_cache #(.INDEX_BITS(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .cpu       (cpu),
    .mem       (mem),
    .HIT_COUNT (HIT_COUNT),
    .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

`ifdef DCACHE_STATS_EN
  localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] STAT_MASK = 32'h0;
`endif

  typedef struct { bit chk; logic [31:0] exp; logic [31:0] addr; } exp_t;
  typedef struct { bit wr; logic [27:0] addr; int lat; } txn_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sbq[$];
  txn_t         txlog[$];
  logic [7:0]   ref_mem [logic [31:0]];
  logic [127:0] bk_mem  [logic [27:0]];
  int           lat_cfg = -1;
  logic [31:0]  last_rd = 32'd0;
  logic [127:0] last_wb = '0;
  int           hit_model = 0;
  int           miss_model = 0;
  bit           hung = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] init_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int w = 0; w < 4; w++)
      b[w*32 +: 32] = ({4'b0, ba} * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(w + 1));
    return b;
  endfunction

  function automatic logic [127:0] bk_block(input logic [27:0] ba);
    if (bk_mem.exists(ba)) return bk_mem[ba];
    return init_block(ba);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [127:0] b;
    if (ref_mem.exists(a)) return ref_mem[a];
    b = bk_block(a[31:4]);
    return b[{a[3:0], 3'b0} +: 8];
  endfunction

  function automatic logic [127:0] ref_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[i*8 +: 8] = ref_byte({ba, 4'(i)});
    return b;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] rd, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = ref_byte(a);
    h = {ref_byte({a[31:1], 1'b1}), ref_byte({a[31:1], 1'b0})};
    w = {ref_byte({a[31:2], 2'd3}), ref_byte({a[31:2], 2'd2}),
         ref_byte({a[31:2], 2'd1}), ref_byte({a[31:2], 2'd0})};
    case (rd[2:0])
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic void model_store(input logic [2:0] wr, input logic [31:0] a, input logic [31:0] d);
    case (wr[1:0])
      2'b00: ref_mem[a] = d[7:0];
      2'b01: begin
        ref_mem[{a[31:1], 1'b0}] = d[7:0];
        ref_mem[{a[31:1], 1'b1}] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) ref_mem[{a[31:2], 2'(i)}] = d[i*8 +: 8];
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                        input logic [31:0] d, output int stall);
    exp_t e;
    int   exp_stall;
    stall = 0;
    if (hung) return;
    txlog.delete();
    cpu.READ = rd; cpu.WRITE = wr; cpu.ADDRESS = a; cpu.WRITE_DATA = d;
    e.addr = a;
    if (wr[2]) begin
      e.chk = rd[3];
      e.exp = last_rd;
      model_store(wr, a, d);
    end else begin
      e.chk = 1'b1;
      e.exp = model_load(rd, a);
      last_rd = e.exp;
    end
    sbq.push_back(e);
    @(negedge CLK);
    while (cpu.BUSYWAIT !== 1'b0 && !hung) begin
      stall++;
      if (stall > 200) begin
        hung = 1;
        checks++; errors++;
        $display("FAIL busywait_timeout: addr %h still stalled after %0d cycles", a, stall);
      end else begin
        @(negedge CLK);
      end
    end
    @(posedge CLK);
    #1;
    cpu.READ = 4'b0; cpu.WRITE = 3'b0;
    if (hung) return;
    if (stall == 0) hit_model++; else miss_model++;
    exp_stall = 0;
    if (txlog.size() > 0) begin
      exp_stall = 2;
      foreach (txlog[i]) exp_stall += txlog[i].lat + 1;
    end
    check32("miss_penalty", 32'(stall), 32'(exp_stall));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin : monitor
    exp_t m;
    if (!RESET && (cpu.READ[3] || cpu.WRITE[2]) && cpu.BUSYWAIT === 1'b0) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: response at addr %h with no expectation", cpu.ADDRESS);
      end else begin
        m = sbq.pop_front();
        if (m.chk) check32("read_data", cpu.READ_DATA, m.exp);
      end
    end
  end

  // ---------------- memory responder ----------------
  bit   act = 0;
  int   cnt = 0;
  txn_t cur;
  always @(negedge CLK) begin : responder
    if (RESET) begin
      act = 0;
      mem.MEM_BUSYWAIT = 1'b0;
    end else if (mem.MEM_READ || mem.MEM_WRITE) begin
      check32("mem_rw_exclusive", 32'(mem.MEM_READ & mem.MEM_WRITE), 32'd0);
      if (!act) begin
        act      = 1;
        cur.wr   = mem.MEM_WRITE;
        cur.addr = mem.MEM_ADDRESS;
        cur.lat  = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
        cnt      = cur.lat;
        txlog.push_back(cur);
        if (cur.wr) begin
          last_wb = mem.MEM_WRITE_DATA;
          check128("writeback_data", mem.MEM_WRITE_DATA, ref_block(cur.addr));
        end else begin
          check32("refill_addr", {4'b0, mem.MEM_ADDRESS}, {4'b0, cpu.ADDRESS[31:4]});
        end
      end
      if (cnt > 0) begin
        mem.MEM_BUSYWAIT = 1'b1;
        cnt--;
      end else begin
        mem.MEM_BUSYWAIT = 1'b0;
        act = 0;
        if (cur.wr) bk_mem[cur.addr] = mem.MEM_WRITE_DATA;
        else        mem.MEM_READ_DATA = bk_block(cur.addr);
      end
    end else begin
      act = 0;
      mem.MEM_BUSYWAIT = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [31:0] bases [4] = '{32'h0, 32'h80, 32'h100, 32'hFFFF_FF80};

  initial begin
    int st;
    int wait_cnt;
    RESET = 1'b1;
    cpu.READ = 4'b0; cpu.WRITE = 3'b0; cpu.ADDRESS = 32'h0; cpu.WRITE_DATA = 32'h0;
    mem.MEM_BUSYWAIT = 1'b0; mem.MEM_READ_DATA = '0;
    bk_mem[28'h4] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    repeat (2) @(posedge CLK);
    #1;
    check32("reset_busywait", 32'(cpu.BUSYWAIT), 32'd0);
    check32("reset_mem_read", 32'(mem.MEM_READ), 32'd0);
    check32("reset_mem_write", 32'(mem.MEM_WRITE), 32'd0);
    check32("reset_read_data", cpu.READ_DATA, 32'd0);
    check32("reset_hit_count", HIT_COUNT, 32'd0);
    @(negedge CLK) RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Cold load, memory busy for 5 cycles.
    lat_cfg = 5;
    do_req(4'b1010, 3'b000, 32'h40, 32'h0, st);
    check32("cold_stall", 32'(st), 32'd8);
    check32("cold_txn_count", 32'(txlog.size()), 32'd1);
    if (txlog.size() > 0) begin
      check32("cold_txn_is_read", 32'(txlog[0].wr), 32'd0);
      check32("cold_mem_addr", {4'b0, txlog[0].addr}, 32'h4);
    end
    check32("cold_read_hold", cpu.READ_DATA, 32'h11111111);
    check32("cold_miss_count", MISS_COUNT, 32'd1 & STAT_MASK);
    lat_cfg = -1;

    // Store hit then load hits.
    do_req(4'b0000, 3'b110, 32'h44, 32'h8000ABCD, st);
    check32("sw_hit_stall", 32'(st), 32'd0);
    do_req(4'b1001, 3'b000, 32'h46, 32'h0, st);
    check32("lh_hit_stall", 32'(st), 32'd0);
    check32("lh_value", cpu.READ_DATA, 32'hFFFF8000);
    do_req(4'b1100, 3'b000, 32'h44, 32'h0, st);
    check32("lbu_hit_stall", 32'(st), 32'd0);
    check32("lbu_value", cpu.READ_DATA, 32'h000000CD);
    check32("hit_count_3", HIT_COUNT, 32'd3 & STAT_MASK);

    // Dirty eviction: write back then refill.
    do_req(4'b1010, 3'b000, 32'h440, 32'h0, st);
    check32("dirty_txn_count", 32'(txlog.size()), 32'd2);
    if (txlog.size() == 2) begin
      check32("dirty_first_is_write", 32'(txlog[0].wr), 32'd1);
      check32("dirty_wb_addr", {4'b0, txlog[0].addr}, 32'h4);
      check32("dirty_second_is_read", 32'(txlog[1].wr), 32'd0);
      check32("dirty_refill_addr", {4'b0, txlog[1].addr}, 32'h44);
    end
    check32("dirty_wb_word1", last_wb[63:32], 32'h8000ABCD);

    // Clean eviction: refill only.
    do_req(4'b1010, 3'b000, 32'h840, 32'h0, st);
    check32("clean_txn_count", 32'(txlog.size()), 32'd1);
    if (txlog.size() > 0) begin
      check32("clean_txn_is_read", 32'(txlog[0].wr), 32'd0);
      check32("clean_refill_addr", {4'b0, txlog[0].addr}, 32'h84);
    end

    // Simultaneous load and store: store wins, READ_DATA unchanged.
    do_req(4'b1010, 3'b100, 32'h41, 32'h0000005A, st);
    check32("combo_read_hold", cpu.READ_DATA, last_rd);
    do_req(4'b1100, 3'b000, 32'h41, 32'h0, st);
    check32("combo_byte", cpu.READ_DATA, 32'h0000005A);
    do_req(4'b1010, 3'b000, 32'h441, 32'h0, st);
    check32("combo_dirty_wb", (txlog.size() > 0) ? 32'(txlog[0].wr) : 32'd0, 32'd1);

    // Reset in the middle of a refill.
    do_req(4'b1010, 3'b000, 32'h10, 32'h0, st);
    do_req(4'b1010, 3'b000, 32'h14, 32'h0, st);
    check32("prefill_hit_stall", 32'(st), 32'd0);
    lat_cfg = 6;
    cpu.READ = 4'b1010; cpu.ADDRESS = 32'h20;
    wait_cnt = 0;
    @(negedge CLK);
    while (mem.MEM_READ !== 1'b1 && wait_cnt < 20) begin
      wait_cnt++;
      @(negedge CLK);
    end
    check32("rst_saw_allocate", 32'(mem.MEM_READ), 32'd1);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    cpu.READ = 4'b0;
    #1;
    check32("rst_mem_read", 32'(mem.MEM_READ), 32'd0);
    check32("rst_busywait", 32'(cpu.BUSYWAIT), 32'd0);
    check32("rst_read_data", cpu.READ_DATA, 32'd0);
    sbq.delete();
    ref_mem.delete();
    last_rd = 32'd0;
    hit_model = 0;
    miss_model = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    check32("rst_miss_count", MISS_COUNT, 32'd0);
    @(posedge CLK);
    #1;
    lat_cfg = -1;
    do_req(4'b1010, 3'b000, 32'h10, 32'h0, st);
    check32("rst_remiss", 32'(st != 0), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 300 && !hung; n++) begin
      int          op;
      logic [31:0] a;
      a  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 127));
      op = int'($urandom_range(0, 9));
      if (op < 5)
        do_req({1'b1, f3s[$urandom_range(0, 4)]}, 3'b000, a, 32'h0, st);
      else if (op < 9)
        do_req(4'b0000, {1'b1, 2'($urandom_range(0, 2))}, a, $urandom, st);
      else
        do_req({1'b1, f3s[$urandom_range(0, 4)]}, {1'b1, 2'($urandom_range(0, 2))}, a, $urandom, st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
    end

    check32("final_hit_count", HIT_COUNT, 32'(hit_model) & STAT_MASK);
    check32("final_miss_count", MISS_COUNT, 32'(miss_model) & STAT_MASK);
    check32("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
